multiplier: RTL and testbench

- Sequential shift-add multiplier for the CPU execution unit; the counterpart of the divider.
- Serves x86 MUL/IMUL: 8x8->16 when width=0 (AL*r8 -> AX) and 16x16->32 when width=1 (AX*r16 -> DX:AX).
- Handshake matches the divider (start/busy/done), so the microcode sequencer drives both the same way.
- Also produces the x86 CF/OF overflow condition.

---
 rtl/multiplier_if.sv | 31 +++
 rtl/multiplier.sv | 181 ++++++++++++++++++
 tb/tb_multiplier.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// ============================================================================
// Module      : multiplier_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multiplier_if;
    logic        start;
    logic        width;
    logic        is_signed;
    logic [15:0] multiplicand;
    logic [15:0] multiplier_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] product;

    modport master (
        output start, width, is_signed, multiplicand, multiplier_in,
        input  busy, done, overflow, product
    );

    modport slave (
        input  start, width, is_signed, multiplicand, multiplier_in,
        output busy, done, overflow, product
    );
endinterface

`default_nettype wire

// File: rtl/multiplier.sv
// ============================================================================
// Module      : multiplier
// Description : Sequential shift-add multiplier for x86 MUL/IMUL (8x8->16 and
//               16x16->32) with CF/OF overflow. Define MUL_RADIX4_EN to retire
//               two multiplier bits per cycle (4/8 cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier (
    input  wire logic   clk,
    input  wire logic   rst_n,
    multiplier_if.slave bus
);

`ifdef MUL_RADIX4_EN
    localparam logic [4:0] c_CNT8  = 5'd4;
    localparam logic [4:0] c_CNT16 = 5'd8;
    localparam int         c_SHIFT = 2;
`else
    localparam logic [4:0] c_CNT8  = 5'd8;
    localparam logic [4:0] c_CNT16 = 5'd16;
    localparam int         c_SHIFT = 1;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_step;
    logic        w_finish;

    logic [4:0]  r_count;
    logic [16:0] r_mag_a;
    logic [15:0] r_mag_b;
    logic [31:0] r_acc;
    logic        r_neg;
    logic        r_width;
    logic        r_signed;
    logic        r_done;
    logic        r_overflow;
    logic [31:0] r_product;

    logic [16:0] w_a_ext;
    logic [16:0] w_b_ext;
    logic [16:0] w_a_mag;
    logic [16:0] w_b_mag;
    logic [31:0] w_acc_next;
    logic [15:0] w_b_next;
    logic [15:0] w_mag16;
    logic [31:0] w_prod;
    logic        w_ovf;

    // Operand sign-extension to 17 bits so |-32768| does not wrap
    always_comb begin
        if (bus.width) begin
            w_a_ext = {bus.is_signed & bus.multiplicand[15], bus.multiplicand};
            w_b_ext = {bus.is_signed & bus.multiplier_in[15], bus.multiplier_in};
        end else begin
            w_a_ext = {{9{bus.is_signed & bus.multiplicand[7]}}, bus.multiplicand[7:0]};
            w_b_ext = {{9{bus.is_signed & bus.multiplier_in[7]}}, bus.multiplier_in[7:0]};
        end
        w_a_mag = w_a_ext[16] ? (~w_a_ext + 17'd1) : w_a_ext;
        w_b_mag = w_b_ext[16] ? (~w_b_ext + 17'd1) : w_b_ext;
    end

`ifdef MUL_RADIX4_EN
    logic [17:0] r_mag_a3;
    logic [17:0] w_addend;
    logic [17:0] w_sum;

    always_comb begin
        case (r_mag_b[1:0])
            2'd0:    w_addend = 18'd0;
            2'd1:    w_addend = {1'b0, r_mag_a};
            2'd2:    w_addend = {r_mag_a, 1'b0};
            default: w_addend = r_mag_a3;
        endcase
        w_sum      = {2'b00, r_acc[31:16]} + w_addend;
        w_acc_next = {w_sum, r_acc[15:2]};
    end
`else
    logic [16:0] w_sum;

    always_comb begin
        w_sum      = {1'b0, r_acc[31:16]} + (r_mag_b[0] ? r_mag_a : 17'd0);
        w_acc_next = {w_sum, r_acc[15:1]};
    end
`endif

    // An 8-bit product ends up in acc[23:8] after eight bit positions
    always_comb begin
        w_b_next = r_mag_b >> c_SHIFT;
        w_mag16  = w_acc_next[23:8];
        if (r_width) begin
            w_prod = r_neg ? (~w_acc_next + 32'd1) : w_acc_next;
            w_ovf  = r_signed ? (w_prod[31:16] != {16{w_prod[15]}})
                              : (w_prod[31:16] != 16'h0000);
        end else begin
            w_prod = {16'h0000, (r_neg ? (~w_mag16 + 16'd1) : w_mag16)};
            w_ovf  = r_signed ? (w_prod[15:8] != {8{w_prod[7]}})
                              : (w_prod[15:8] != 8'h00);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_count == 5'd1) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_count    <= 5'd0;
            r_mag_a    <= 17'd0;
            r_mag_b    <= 16'd0;
            r_acc      <= 32'd0;
            r_neg      <= 1'b0;
            r_width    <= 1'b0;
            r_signed   <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_product  <= 32'd0;
`ifdef MUL_RADIX4_EN
            r_mag_a3   <= 18'd0;
`endif
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (w_load) begin
                r_width  <= bus.width;
                r_signed <= bus.is_signed;
                r_neg    <= bus.is_signed & (w_a_ext[16] ^ w_b_ext[16]);
                r_mag_a  <= w_a_mag;
                r_mag_b  <= w_b_mag[15:0];
                r_acc    <= 32'd0;
                r_count  <= bus.width ? c_CNT16 : c_CNT8;
`ifdef MUL_RADIX4_EN
                r_mag_a3 <= {1'b0, w_a_mag} + {w_a_mag, 1'b0};
`endif
            end
            if (w_step) begin
                r_acc   <= w_acc_next;
                r_mag_b <= w_b_next;
                r_count <= r_count - 5'd1;
            end
            if (w_finish) begin
                r_product  <= w_prod;
                r_overflow <= w_ovf;
                r_done     <= 1'b1;
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.product  = r_product;

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ============================================================================
// Module      : tb_multiplier
// Description : Directed and model-checked bench for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier;

`ifdef MUL_RADIX4_EN
    localparam int c_N8  = 4;
    localparam int c_N16 = 8;
`else
    localparam int c_N8  = 8;
    localparam int c_N16 = 16;
`endif
    localparam int c_MAX_WAIT = 40;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    multiplier_if bus ();

    multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Issues one operation and waits (bounded) for done; lat = posedges after start edge
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic w, input logic s,
                          output logic [31:0] p, output logic ov, output int lat);
        @(negedge clk);
        bus.start = 1'b1; bus.width = w; bus.is_signed = s;
        bus.multiplicand = a; bus.multiplier_in = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.multiplicand = 16'hDEAD; bus.multiplier_in = 16'hBEEF;
        lat = 0;
        while (!bus.done && lat < c_MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        p  = bus.product;
        ov = bus.overflow;
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic w, input logic s,
                                  output logic [31:0] p, output logic o);
        longint sa, sb, pr;
        if (w) begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
        end else begin
            sa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            sb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end
        pr = sa * sb;
        if (w) begin
            p = pr[31:0];
            o = s ? (p[31:16] != {16{p[15]}}) : (p[31:16] != 16'h0);
        end else begin
            p = {16'h0, pr[15:0]};
            o = s ? (p[15:8] != {8{p[7]}}) : (p[15:8] != 8'h0);
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++; if (bus.overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        vectors++; if (bus.product !== 32'h0)  begin miscompares++; $display("FAIL reset_product: got %h want 0", bus.product); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned16();
        @(negedge clk);
        bus.start = 1'b1; bus.width = 1'b1; bus.is_signed = 1'b0;
        bus.multiplicand = 16'hFFFF; bus.multiplier_in = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 1; i <= c_N16; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.done !== (i == c_N16)) begin
                miscompares++; $display("FAIL u16_done_cycle%0d: got %b want %b", i, bus.done, (i == c_N16));
            end
            vectors++;
            if (bus.busy !== (i < c_N16)) begin
                miscompares++; $display("FAIL u16_busy_cycle%0d: got %b want %b", i, bus.busy, (i < c_N16));
            end
        end
        vectors++; if (bus.product !== 32'hFFFE0001) begin miscompares++; $display("FAIL u16_product: got %h want fffe0001", bus.product); end
        vectors++; if (bus.overflow !== 1'b1)        begin miscompares++; $display("FAIL u16_overflow: got %b want 1", bus.overflow); end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        w;
        logic        s;
        logic [31:0] p;
        logic        o;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[12];
        logic [31:0] p;
        logic        ov;
        int          lat;
        tbl[0]  = '{16'h5A80, 16'hC380, 1'b0, 1'b1, 32'h00004000, 1'b1};
        tbl[1]  = '{16'h0080, 16'h0001, 1'b0, 1'b1, 32'h0000FF80, 1'b0};
        tbl[2]  = '{16'h00FF, 16'h77FF, 1'b0, 1'b1, 32'h00000001, 1'b0};
        tbl[3]  = '{16'h00FF, 16'h00FF, 1'b0, 1'b0, 32'h0000FE01, 1'b1};
        tbl[4]  = '{16'h0010, 16'h000F, 1'b0, 1'b0, 32'h000000F0, 1'b0};
        tbl[5]  = '{16'h8000, 16'hFFFF, 1'b1, 1'b1, 32'h00008000, 1'b1};
        tbl[6]  = '{16'h7FFF, 16'h0002, 1'b1, 1'b1, 32'h0000FFFE, 1'b1};
        tbl[7]  = '{16'hFFFE, 16'h0003, 1'b1, 1'b1, 32'hFFFFFFFA, 1'b0};
        tbl[8]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000, 1'b1};
        tbl[9]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 32'h00000000, 1'b0};
        tbl[10] = '{16'h1234, 16'h0010, 1'b1, 1'b0, 32'h00012340, 1'b1};
        tbl[11] = '{16'h00FD, 16'h0005, 1'b0, 1'b1, 32'h0000FFF1, 1'b0};
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].s, p, ov, lat);
            vectors++;
            if (p !== tbl[i].p) begin
                miscompares++; $display("FAIL dir%0d_product: got %h want %h", i, p, tbl[i].p);
            end
            vectors++;
            if (ov !== tbl[i].o) begin
                miscompares++; $display("FAIL dir%0d_overflow: got %b want %b", i, ov, tbl[i].o);
            end
            vectors++;
            if (lat !== (tbl[i].w ? c_N16 : c_N8)) begin
                miscompares++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, (tbl[i].w ? c_N16 : c_N8));
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int extra_done;
        @(negedge clk);
        bus.start = 1'b1; bus.width = 1'b1; bus.is_signed = 1'b0;
        bus.multiplicand = 16'h0003; bus.multiplier_in = 16'h0005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk);
        bus.start = 1'b1; bus.width = 1'b0; bus.is_signed = 1'b1;
        bus.multiplicand = 16'hFFFF; bus.multiplier_in = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat++;
        while (!bus.done && lat < c_MAX_WAIT) begin @(posedge clk); #1; lat++; end
        vectors++; if (lat !== c_N16)               begin miscompares++; $display("FAIL ignore_latency: got %0d want %0d", lat, c_N16); end
        vectors++; if (bus.product !== 32'h0000000F) begin miscompares++; $display("FAIL ignore_product: got %h want 0000000f", bus.product); end
        vectors++; if (bus.overflow !== 1'b0)       begin miscompares++; $display("FAIL ignore_overflow: got %b want 0", bus.overflow); end
        extra_done = 0;
        repeat (c_N16 + 2) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) extra_done++;
        end
        vectors++; if (extra_done !== 0) begin miscompares++; $display("FAIL ignore_no_second_op: got %0d active cycles want 0", extra_done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] p;
        logic        ov;
        int          lat;
        int          hold_bad;
        run_op(16'h0102, 16'h0003, 1'b1, 1'b0, p, ov, lat);
        vectors++; if (p !== 32'h00000306) begin miscompares++; $display("FAIL b2b_first_product: got %h want 00000306", p); end
        bus.start = 1'b1; bus.width = 1'b0; bus.is_signed = 1'b1;
        bus.multiplicand = 16'h00FF; bus.multiplier_in = 16'h00FF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %b want 1", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_single: got %b want 0", bus.done); end
        lat = 0;
        hold_bad = 0;
        while (!bus.done && lat < c_MAX_WAIT) begin
            if (bus.product !== 32'h00000306) hold_bad++;
            @(posedge clk); #1;
            lat++;
        end
        vectors++; if (hold_bad !== 0)          begin miscompares++; $display("FAIL b2b_hold: got %0d changed cycles want 0", hold_bad); end
        vectors++; if (lat !== c_N8)            begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", lat, c_N8); end
        vectors++; if (bus.product !== 32'h1)   begin miscompares++; $display("FAIL b2b_second_product: got %h want 00000001", bus.product); end
        vectors++; if (bus.overflow !== 1'b0)   begin miscompares++; $display("FAIL b2b_second_overflow: got %b want 0", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        bus.start = 1'b1; bus.width = 1'b1; bus.is_signed = 1'b0;
        bus.multiplicand = 16'hFFFF; bus.multiplier_in = 16'hFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0)     begin miscompares++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0)     begin miscompares++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        vectors++; if (bus.overflow !== 1'b0) begin miscompares++; $display("FAIL midrst_overflow: got %b want 0", bus.overflow); end
        vectors++; if (bus.product !== 32'h0) begin miscompares++; $display("FAIL midrst_product: got %h want 0", bus.product); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (c_N16 + 4) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) stray++;
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d active cycles want 0", stray); end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        w, s, exp_o, ov;
        logic [31:0] exp_p, p;
        int          lat;
        for (int n = 0; n < 600; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            w = 1'($urandom);
            s = 1'($urandom);
            if (n % 8 == 0) a = 16'h0000;
            if (n % 8 == 4) b = 16'h0000;
            model(a, b, w, s, exp_p, exp_o);
            run_op(a, b, w, s, p, ov, lat);
            vectors++;
            if (p !== exp_p) begin
                miscompares++; $display("FAIL rnd%0d_product: a=%h b=%h w=%b s=%b got %h want %h", n, a, b, w, s, p, exp_p);
            end
            vectors++;
            if (ov !== exp_o) begin
                miscompares++; $display("FAIL rnd%0d_overflow: a=%h b=%h w=%b s=%b got %b want %b", n, a, b, w, s, ov, exp_o);
            end
            vectors++;
            if (lat !== (w ? c_N16 : c_N8)) begin
                miscompares++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, (w ? c_N16 : c_N8));
            end
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        bus.start        = 1'b0;
        bus.width        = 1'b0;
        bus.is_signed    = 1'b0;
        bus.multiplicand = 16'h0;
        bus.multiplier_in = 16'h0;
        test_reset();
        test_unsigned16();
        test_directed();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
